cpu_prefetch_queue: RTL and testbench
=====================================

// Module: cpu_prefetch_queue
// PURPOSE
//  Parametrised instruction fetch/prefetch unit for the ARM7TDMI core. It replaces the one-shot
//  "read memory, latch IR" control step with autonomous fetching of up to DEPTH instructions ahead.
//  Supports ARM (word) and Thumb (halfword) modes, and flushes/redirects on branches or exceptions.
//  Sits between the bus interface and the decode stage; decode pops tagged instructions with their PC.
// PARAMETERS
//  DEPTH   3   max instructions buffered + in flight (ARM7 pipeline depth); >=1
//  ADDR_W  32  address width
//  DATA_W  32  bus read data width; must be 32
// PORTS
//  clk            in   1       core clock
//  reset          in   1       synchronous, active-high reset
//  thumb_i        in   1       CPSR.T; sampled at request issue; changes only legal alongside flush_i
//  flush_i        in   1       redirect: discard queue and in-flight fetch
//  flush_addr_i   in   ADDR_W  new fetch address (aligned internally)
//  mem_req_o      out  1       fetch request valid
//  mem_addr_o     out  ADDR_W  fetch address
//  mem_size_o     out  1       0=halfword, 1=word
//  mem_ack_i      in   1       request accepted, rdata valid same cycle
//  mem_rdata_i    in   DATA_W  read data
//  instr_valid_o  out  1       head entry valid
//  instr_o        out  32      instruction (Thumb: {16'h0, halfword})
//  instr_pc_o     out  ADDR_W  address of instr_o
//  instr_thumb_o  out  1       mode the entry was fetched in
//  instr_ready_i  in   1       decode pops head when valid&ready
// BEHAVIOUR
//  - Reset: fetch_pc=0, queue empty, discard=0. All outputs 0 during and on the cycle after reset.
//    mem_req_o first rises on the 2nd cycle after reset deasserts.
//  - Issue: mem_req_o=1 when count + inflight < DEPTH and no flush this cycle.
//    Address/size are driven from fetch_pc/thumb_i. Request is held stable until mem_ack_i. At most
//    one outstanding request.
//  - On ack: push {data, pc, thumb}. fetch_pc += 2 (Thumb) or 4 (ARM), wrapping mod 2^ADDR_W.
//  - Thumb data: mem_rdata_i[15:0] if addr[1]==0, else [31:16]; zero-extended.
//  - Pop: on instr_valid_o & instr_ready_i the head advances. Push and pop in the same cycle leave
//    count unchanged; pop when empty is a no-op. Head is visible one cycle after ack (registered);
//    no bypass.
//  - Flush (highest priority):
//    - Queue emptied next cycle; instr_valid_o=0 that cycle.
//    - fetch_pc <= flush_addr_i & ~3 (ARM) or & ~1 (Thumb, per thumb_i).
//    - An outstanding un-acked request is dropped; mem_req_o deasserts for one cycle.
//    - An ack coinciding with flush is discarded and fetch_pc is NOT advanced.
//    - A pop coinciding with flush is honoured by decode but has no queue effect.
//    - Refetch begins the cycle after flush.
//  - Full: count==DEPTH => mem_req_o=0 until a pop; no push can be lost (issue gated by
//    count+inflight).
//  - Counters: count width $clog2(DEPTH+1); rd/wr ptrs wrap at DEPTH (non-power-of-2 legal).
//  - Reset mid-fetch: in-flight request abandoned, no output asserted.
// STRUCTURE
//  - control_types_pkg gains:
//    - typedef struct packed {logic [31:0] instr; logic [ADDR_W-1:0] pc; logic thumb;} fetch_entry_t
//    - localparams FETCH_STEP_ARM=4, FETCH_STEP_THUMB=2.
//  - Sub-module prefetch_fifo: synchronous circular FIFO of fetch_entry_t (push/pop/clear/count).
//  - Top level holds fetch_pc, request FSM (IDLE -> REQ -> IDLE on ack/flush), Thumb lane select.
//  - control_util_pkg::fetch_next_instr() becomes a pop request to this block.
// TESTING
//  1. ARM stream: reset, flush to 0x0800_0000, ack every cycle, ready=1 -> instr_pc_o
//     0x0800_0000, _04, _08... in order, data matches memory model.
//  2. Thumb: thumb_i=1, flush to 0x0800_0103 -> pcs 0x102, 0x104, 0x106; lane alternates
//     [31:16], [15:0], [31:16]; mem_size_o=0.
//  3. Backpressure: ready=0, DEPTH=3 -> exactly 3 acks then mem_req_o=0; one pop -> exactly one
//     new request.
//  4. Flush with ack same cycle at pc 0x100, flush to 0x200 -> 0x100 data never appears; next
//     valid pc=0x200.
//  5. Flush while request pending (ack delayed 3 cycles) -> old address dropped, next mem_addr_o
//     = flush target.
//  6. Reset asserted with full queue and pending request -> outputs 0 next cycle; after release
//     first fetch at 0x0.

Source files
------------

// File: rtl/cpu_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Entry layout, fetch step sizes and request FSM states.
package cpu_prefetch_queue_pkg;

  localparam int unsigned FETCH_ADDR_W     = 32;
  localparam int unsigned FETCH_STEP_ARM   = 4;
  localparam int unsigned FETCH_STEP_THUMB = 2;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic                    thumb;
  } fetch_entry_t;

  typedef enum logic {
    FS_IDLE,
    FS_REQ
  } fetch_state_e;

endpackage

// File: rtl/cpu_prefetch_queue_fifo.sv
// Circular FIFO of fetch entries with push/pop/clear and occupancy count.
// Ports: clk, reset, clear_i, push_i, data_i, pop_i, data_o, count_o.
module cpu_prefetch_queue_fifo
  import cpu_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter type T = fetch_entry_t,
  localparam int unsigned PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH, so non-power-of-2 depths work.
  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i &&
    ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i && !reset) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/cpu_prefetch_queue.sv
// Autonomous ARM/Thumb instruction prefetcher feeding decode.
// Ports: bus request/ack side, flush redirect, tagged instr pop side.
module cpu_prefetch_queue
  import cpu_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              thumb_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_size_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_thumb_o,
  input  logic              instr_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              thumb;
  } entry_t;

  fetch_state_e      state_q;
  logic              req_q;
  logic              thumb_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] flush_pc;
  logic [CW-1:0]     count;
  logic [31:0]       fetched;
  logic              push;
  logic              pop;
  logic              valid;
  entry_t            push_e;
  entry_t            head_e;

  assign valid = (count != '0);
  assign push  = req_q && mem_ack_i && !flush_i;
  assign pop   = valid && instr_ready_i && !flush_i;

  // Thumb halfword lane is picked by address bit 1.
  assign fetched = !thumb_q ? mem_rdata_i[31:0] :
    pc_q[1] ? {16'h0, mem_rdata_i[31:16]} :
              {16'h0, mem_rdata_i[15:0]};

  assign pc_d = pc_q + (thumb_q ?
    ADDR_W'(FETCH_STEP_THUMB) :
    ADDR_W'(FETCH_STEP_ARM));

  assign flush_pc = thumb_i ?
    {flush_addr_i[ADDR_W-1:1], 1'b0} :
    {flush_addr_i[ADDR_W-1:2], 2'b00};

  assign push_e = '{
    instr: fetched,
    pc:    pc_q,
    thumb: thumb_q
  };

  // Issue only from IDLE with room for the reply, so one
  // outstanding request can never overflow the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      req_q   <= 1'b0;
      thumb_q <= 1'b0;
      pc_q    <= '0;
    end else if (flush_i) begin
      state_q <= FS_IDLE;
      req_q   <= 1'b0;
      thumb_q <= thumb_i;
      pc_q    <= flush_pc;
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          if (count < CW'(DEPTH)) begin
            state_q <= FS_REQ;
            req_q   <= 1'b1;
            thumb_q <= thumb_i;
          end
        end
        FS_REQ: begin
          if (mem_ack_i) begin
            state_q <= FS_IDLE;
            req_q   <= 1'b0;
            pc_q    <= pc_d;
          end
        end
      endcase
    end
  end

  cpu_prefetch_queue_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_i),
    .push_i  (push),
    .data_i  (push_e),
    .pop_i   (pop),
    .data_o  (head_e),
    .count_o (count)
  );

  assign mem_req_o     = req_q;
  assign mem_addr_o    = req_q ? pc_q : '0;
  assign mem_size_o    = req_q && !thumb_q;
  assign instr_valid_o = valid;
  assign instr_o       = valid ? head_e.instr : '0;
  assign instr_pc_o    = valid ? head_e.pc : '0;
  assign instr_thumb_o = valid && head_e.thumb;

endmodule

// File: tb/tb_cpu_prefetch_queue.sv
// Self-checking bench for cpu_prefetch_queue.
// Queue-based reference model plus directed scenario checks.
module tb_cpu_prefetch_queue;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        thumb_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_size_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_thumb_o;
  logic        instr_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // 0: ack whenever asked, 1: never, 2: ack on 4th req cycle
  int ack_mode = 1;
  int req_age = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        thumb;
  } ent_t;

  ent_t        q[$];
  ent_t        mdl_e;
  logic [31:0] mdl_w;
  logic [31:0] exp_pc = '0;
  logic        exp_thumb = 1'b0;
  logic        model_en = 1'b0;
  logic        after_rst = 1'b0;
  int          n_acks = 0;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_thumb[$];

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    logic [15:0] i;
    i = a[17:2];
    return {~i, i};
  endfunction

  assign mem_ack_i = (ack_mode == 0) ||
    (ack_mode == 2 && req_age >= 3);
  assign mem_rdata_i = mem_word(mem_addr_o);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    req_age <= mem_req_o ? req_age + 1 : 0;
  end

  cpu_prefetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .thumb_i       (thumb_i),
    .flush_i       (flush_i),
    .flush_addr_i  (flush_addr_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_size_o    (mem_size_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_thumb_o (instr_thumb_o),
    .instr_ready_i (instr_ready_i)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare at negedge, then advance the model over the
  // coming posedge using the (now stable) inputs.
  always @(negedge clk) begin
    if (model_en) begin
      if (after_rst) begin
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_size", mem_size_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", instr_pc_o, 0);
        chk("rst_thumb", instr_thumb_o, 0);
      end
      chk("valid", instr_valid_o, q.size() != 0);
      if (q.size() != 0) begin
        chk("head_pc", instr_pc_o, q[0].pc);
        chk("head_instr", instr_o, q[0].instr);
        chk("head_thumb", instr_thumb_o, q[0].thumb);
      end
      if (mem_req_o) begin
        chk("req_addr", mem_addr_o, exp_pc);
        chk("req_size", mem_size_o, !exp_thumb);
        chk("req_room", q.size() < DEPTH, 1);
      end
    end
    after_rst = reset;
    if (reset) begin
      q.delete();
      exp_pc = '0;
      exp_thumb = 1'b0;
      model_en = 1'b1;
    end else if (flush_i) begin
      q.delete();
      exp_thumb = thumb_i;
      exp_pc = thumb_i ? (flush_addr_i & ~32'd1)
                       : (flush_addr_i & ~32'd3);
    end else begin
      if (q.size() != 0 && instr_ready_i) begin
        pop_pc.push_back(instr_pc_o);
        pop_instr.push_back(instr_o);
        pop_thumb.push_back(instr_thumb_o);
        void'(q.pop_front());
      end
      if (mem_req_o && mem_ack_i) begin
        mdl_w = mem_word(exp_pc);
        mdl_e.pc = exp_pc;
        mdl_e.thumb = exp_thumb;
        if (!exp_thumb) mdl_e.instr = mdl_w;
        else if (exp_pc[1]) mdl_e.instr = {16'h0, mdl_w[31:16]};
        else mdl_e.instr = {16'h0, mdl_w[15:0]};
        q.push_back(mdl_e);
        n_acks++;
        exp_pc = exp_pc + (exp_thumb ? 32'd2 : 32'd4);
      end
    end
  end

  task automatic clr_log();
    pop_pc.delete();
    pop_instr.delete();
    pop_thumb.delete();
  endtask

  task automatic do_flush(
    input logic [31:0] a,
    input logic        t
  );
    flush_i = 1'b1;
    flush_addr_i = a;
    thumb_i = t;
    step();
    flush_i = 1'b0;
  endtask

  task automatic wait_pops(input int n, input string nm);
    for (int k = 0; k < 80 && pop_pc.size() < n; k++) step();
    chk(nm, pop_pc.size() >= n, 1);
  endtask

  task automatic wait_req(input string nm);
    for (int k = 0; k < 20 && !mem_req_o; k++) step();
    chk(nm, mem_req_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1;
    step();
    step();

    // 1: ARM stream
    reset = 1'b0;
    ack_mode = 0;
    instr_ready_i = 1'b1;
    clr_log();
    do_flush(32'h0800_0000, 1'b0);
    wait_pops(4, "arm_timeout");
    if (pop_pc.size() >= 4) begin
      chk("arm_pc0", pop_pc[0], 32'h0800_0000);
      chk("arm_pc1", pop_pc[1], 32'h0800_0004);
      chk("arm_pc2", pop_pc[2], 32'h0800_0008);
      chk("arm_d0", pop_instr[0], 32'hFFFF_0000);
      chk("arm_d1", pop_instr[1], 32'hFFFE_0001);
      chk("arm_t0", pop_thumb[0], 0);
    end

    // 2: Thumb stream with lane selection
    do_flush(32'h0800_0103, 1'b1);
    clr_log();
    wait_req("thm_req_timeout");
    chk("thm_size", mem_size_o, 0);
    wait_pops(3, "thm_timeout");
    if (pop_pc.size() >= 3) begin
      chk("thm_pc0", pop_pc[0], 32'h0800_0102);
      chk("thm_pc1", pop_pc[1], 32'h0800_0104);
      chk("thm_pc2", pop_pc[2], 32'h0800_0106);
      chk("thm_d0", pop_instr[0], 32'h0000_FFBF);
      chk("thm_d1", pop_instr[1], 32'h0000_0041);
      chk("thm_d2", pop_instr[2], 32'h0000_FFBE);
      chk("thm_t0", pop_thumb[0], 1);
    end

    // 3: backpressure fills exactly DEPTH entries
    instr_ready_i = 1'b0;
    base = n_acks;
    do_flush(32'h0000_0300, 1'b0);
    repeat (20) step();
    chk("bp_acks", n_acks - base, 3);
    chk("bp_req_off", mem_req_o, 0);
    chk("bp_valid", instr_valid_o, 1);
    clr_log();
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    repeat (10) step();
    chk("bp_acks2", n_acks - base, 4);
    chk("bp_req_off2", mem_req_o, 0);
    chk("bp_popped", pop_pc.size(), 1);
    if (pop_pc.size() >= 1) chk("bp_pc", pop_pc[0], 32'h300);

    // 4: ack coinciding with flush is discarded
    instr_ready_i = 1'b1;
    ack_mode = 1;
    do_flush(32'h0000_0100, 1'b0);
    for (int k = 0; k < 20 && !(mem_req_o &&
         mem_addr_o == 32'h100); k++) step();
    chk("fa_req_timeout", mem_addr_o, 32'h100);
    clr_log();
    ack_mode = 0;
    do_flush(32'h0000_0200, 1'b0);
    wait_pops(2, "fa_timeout");
    if (pop_pc.size() >= 2) begin
      chk("fa_pc0", pop_pc[0], 32'h200);
      chk("fa_pc1", pop_pc[1], 32'h204);
    end

    // 5: flush while request pending
    ack_mode = 2;
    do_flush(32'h0000_0400, 1'b0);
    for (int k = 0; k < 20 && !(mem_req_o &&
         mem_addr_o == 32'h400); k++) step();
    chk("fp_req_timeout", mem_addr_o, 32'h400);
    step();
    chk("fp_pending", mem_req_o && !mem_ack_i, 1);
    do_flush(32'h0000_0500, 1'b0);
    chk("fp_req_drop", mem_req_o, 0);
    clr_log();
    wait_req("fp_req2_timeout");
    chk("fp_addr", mem_addr_o, 32'h500);
    wait_pops(1, "fp_timeout");
    if (pop_pc.size() >= 1) chk("fp_pc0", pop_pc[0], 32'h500);

    // 6: reset with queued data and a pending request
    instr_ready_i = 1'b0;
    ack_mode = 0;
    base = n_acks;
    do_flush(32'h0000_0600, 1'b0);
    for (int k = 0; k < 30 && n_acks - base < 2; k++) step();
    chk("rs_fill", n_acks - base, 2);
    ack_mode = 1;
    wait_req("rs_req_timeout");
    reset = 1'b1;
    step();
    chk("rs_req", mem_req_o, 0);
    chk("rs_valid", instr_valid_o, 0);
    chk("rs_instr", instr_o, 0);
    reset = 1'b0;
    step();
    chk("rs_req_up", mem_req_o, 1);
    chk("rs_addr0", mem_addr_o, 32'h0);
    chk("rs_size", mem_size_o, 1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
